// File: rtl/tbird_pkg.sv
// tbird_pkg: command codes and button bit positions shared by the taillight front end and its state machine.
package tbird_pkg;
  typedef enum logic [3:0] {
    CMD_IDLE   = 4'b1111,
    CMD_LEFT   = 4'b0111,
    CMD_HAZARD = 4'b1011,
    CMD_RESET  = 4'b1101,
    CMD_RIGHT  = 4'b1110
  } cmd_e;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_HAZARD = 2;
  localparam int BTN_RESET  = 1;
  localparam int BTN_RIGHT  = 0;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser, stable-count debounce and press pulse for one active-low button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n_i,
  output logic level_n_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lvl_q, lvl_d, press_q, press_d, diff, done;
  always_comb begin
    diff = sync_q[1] != lvl_q;
    done = diff && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d = (diff && !done) ? cnt_q + CW'(1) : '0;
    lvl_d = lvl_q ^ done;
    press_d = done & lvl_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b11;
      cnt_q <= '0;
      lvl_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_n_i};
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      press_q <= press_d;
    end
  end
  assign level_n_o = lvl_q;
  assign press_o = press_q;
endmodule

// File: rtl/tbird_button_encoder.sv
// tbird_button_encoder: turns four raw active-low buttons into a stable command code and slow enable for the taillight FSM.
module tbird_button_encoder
  import tbird_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 4,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] buttons_n,
  output logic [3:0] command,
  output logic       enable,
  output logic       hazard_active
);
  localparam int HALF = CLK_HZ / (2 * TICK_HZ);
  localparam int HW = $clog2(HALF);
  logic [3:0] level_n, press;
  logic [HW-1:0] tick_q, tick_d;
  logic en_q, en_d, wrap, fall_tick;
  logic haz_q, haz_d, pend_q, pend_d, rst_req;
  cmd_e cmd_q, cmd_d, cmd_sel;
  logic unused_ok;
  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock(clock),
      .reset(reset),
      .raw_n_i(buttons_n[i]),
      .level_n_o(level_n[i]),
      .press_o(press[i])
    );
  end
  assign unused_ok = ^{level_n[BTN_HAZARD], press[BTN_LEFT], press[BTN_RIGHT]};
  // Command only moves on enable's falling edge, so every rising edge sees a settled code.
  always_comb begin
    wrap = tick_q == HW'(HALF - 1);
    tick_d = wrap ? '0 : tick_q + HW'(1);
    en_d = en_q ^ wrap;
    fall_tick = wrap & en_q;
    haz_d = press[BTN_RESET] ? 1'b0 : haz_q ^ press[BTN_HAZARD];
    pend_d = fall_tick ? 1'b0 : pend_q | press[BTN_RESET];
    rst_req = pend_q | ~level_n[BTN_RESET];
    cmd_sel = rst_req ? CMD_RESET :
              haz_q ? CMD_HAZARD :
              (!level_n[BTN_LEFT] && level_n[BTN_RIGHT]) ? CMD_LEFT :
              (level_n[BTN_LEFT] && !level_n[BTN_RIGHT]) ? CMD_RIGHT : CMD_IDLE;
    cmd_d = fall_tick ? cmd_sel : cmd_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_q <= '0;
      en_q <= 1'b0;
      haz_q <= 1'b0;
      pend_q <= 1'b0;
      cmd_q <= CMD_IDLE;
    end else begin
      tick_q <= tick_d;
      en_q <= en_d;
      haz_q <= haz_d;
      pend_q <= pend_d;
      cmd_q <= cmd_d;
    end
  end
  assign command = cmd_q;
  assign enable = en_q;
  assign hazard_active = haz_q;
endmodule
